// File: rtl/color_convert_dot3_pipe_pkg.sv
// Shared widths, rounding constant, pixel pack/unpack helpers and BT.601 defaults
// for the colour-space dot-product pipe.
package color_convert_pkg;

  function automatic int pw_width(input int din_w, input int coef_w);
    return din_w + coef_w + 1;
  endfunction

  // Three-term sum needs two guard bits over a single product
  function automatic int sw_width(input int din_w, input int coef_w);
    return pw_width(din_w, coef_w) + 2;
  endfunction

  function automatic longint round_const(input int frac_bits);
    return longint'(1) << (frac_bits - 1);
  endfunction

  function automatic int chan_lsb(input int ch, input int width);
    return ch * width;
  endfunction

  function automatic logic [23:0] pack_pix8(input logic [7:0] c2, input logic [7:0] c1,
                                            input logic [7:0] c0);
    return {c2, c1, c0};
  endfunction

  function automatic logic [7:0] unpack_pix8(input logic [23:0] pix, input int ch);
    return pix[chan_lsb(ch, 8) +: 8];
  endfunction

  localparam int BT601_FRAC_BITS = 8;
  localparam int BT601_Y_C0  = 77;
  localparam int BT601_Y_C1  = 150;
  localparam int BT601_Y_C2  = 29;
  localparam int BT601_CB_C0 = -43;
  localparam int BT601_CB_C1 = -85;
  localparam int BT601_CB_C2 = 128;
  localparam int BT601_CR_C0 = 128;
  localparam int BT601_CR_C1 = -107;
  localparam int BT601_CR_C2 = -21;

endpackage

// File: rtl/color_convert_dot3_pipe_if.sv
// Beat-level stream interface for color_convert_dot3_pipe.
// COLOR_CONVERT_SAT_FLAG_EN adds the out_sat / sat_sticky status signals.
interface color_convert_dot3_pipe_if #(
  parameter int DIN_WIDTH  = 8,
  parameter int COEF_WIDTH = 10,
  parameter int DOUT_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [3*DIN_WIDTH-1:0]  in_pix;
  logic [3*COEF_WIDTH-1:0] coef;
  logic [DOUT_WIDTH:0]     offset;
  logic                    out_valid;
  logic                    out_ready;
  logic [DOUT_WIDTH-1:0]   out_data;
`ifdef COLOR_CONVERT_SAT_FLAG_EN
  logic                    out_sat;
  logic                    sat_sticky;

  modport slave (
    input  in_valid, in_pix, coef, offset, out_ready,
    output in_ready, out_valid, out_data, out_sat, sat_sticky
  );
  modport master (
    output in_valid, in_pix, coef, offset, out_ready,
    input  in_ready, out_valid, out_data, out_sat, sat_sticky
  );
`else
  modport slave (
    input  in_valid, in_pix, coef, offset, out_ready,
    output in_ready, out_valid, out_data
  );
  modport master (
    output in_valid, in_pix, coef, offset, out_ready,
    input  in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/color_convert_dot3_pipe_mul_su.sv
// Registered signed coefficient x unsigned pixel multiplier with load enable.
module color_convert_mul_su
  import color_convert_pkg::*;
#(
  parameter  int DIN_WIDTH  = 8,
  parameter  int COEF_WIDTH = 10,
  localparam int PW         = pw_width(DIN_WIDTH, COEF_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic signed [COEF_WIDTH-1:0] a,
  input  logic        [DIN_WIDTH-1:0]  b,
  output logic signed [PW-1:0]         p
);

  logic signed [PW-1:0] ax;
  logic signed [PW-1:0] bx;

  // Pixel gets a zero sign bit so the product stays a plain signed multiply
  assign ax = PW'(a);
  assign bx = $signed(PW'({1'b0, b}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p <= ax * bx;
    end
  end

endmodule

// File: rtl/color_convert_dot3_pipe.sv
// Three-stage dot product: multiply, sum, round/offset/saturate, with a global stall.
// COLOR_CONVERT_SAT_FLAG_EN enables the out_sat / sat_sticky outputs.
module color_convert_dot3_pipe
  import color_convert_pkg::*;
#(
  parameter int DIN_WIDTH  = 8,
  parameter int COEF_WIDTH = 10,
  parameter int FRAC_BITS  = 8,
  parameter int DOUT_WIDTH = 8
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  color_convert_dot3_pipe_if.slave bus
);

  localparam int PW = pw_width(DIN_WIDTH, COEF_WIDTH);
  localparam int SW = sw_width(DIN_WIDTH, COEF_WIDTH);
  localparam int VW = SW + 1;
  localparam logic signed [SW-1:0] RND  = SW'(round_const(FRAC_BITS));
  localparam logic signed [VW-1:0] MAXV = $signed({{(VW-DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}});

  logic                  en;
  logic                  v1, v2, v3;
  logic signed [PW-1:0]  p [3];
  logic [DOUT_WIDTH:0]   off1, off2;
  logic signed [SW-1:0]  sum2;
  logic signed [SW-1:0]  rnd, r;
  logic signed [VW-1:0]  v;
  logic [DOUT_WIDTH-1:0] dout_c, dout_q;
  logic                  sat_c;

  // Whole pipe advances together; out_ready reaches in_ready combinationally
  assign en           = !v3 || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar i = 0; i < 3; i++) begin : g_mul
    localparam int CL = chan_lsb(i, COEF_WIDTH);
    localparam int PL = chan_lsb(i, DIN_WIDTH);
    color_convert_mul_su #(
      .DIN_WIDTH (DIN_WIDTH),
      .COEF_WIDTH(COEF_WIDTH)
    ) u_mul (
      .clk  (ap_clk),
      .rst_n(ap_rst_n),
      .en   (en),
      .a    (bus.coef[CL +: COEF_WIDTH]),
      .b    (bus.in_pix[PL +: DIN_WIDTH]),
      .p    (p[i])
    );
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      off1 <= '0;
      off2 <= '0;
      sum2 <= '0;
    end else if (en) begin
      v1   <= bus.in_valid;
      off1 <= bus.offset;
      v2   <= v1;
      off2 <= off1;
      sum2 <= SW'(p[0]) + SW'(p[1]) + SW'(p[2]);
    end
  end

  // Arithmetic shift of the biased sum rounds halves toward +inf
  assign rnd = sum2 + RND;
  assign r   = rnd >>> FRAC_BITS;
  assign v   = VW'(r) + VW'($signed(off2));

  always_comb begin
    sat_c  = 1'b0;
    dout_c = v[DOUT_WIDTH-1:0];
    if (v < 0) begin
      sat_c  = 1'b1;
      dout_c = '0;
    end else if (v > MAXV) begin
      sat_c  = 1'b1;
      dout_c = '1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v3     <= 1'b0;
      dout_q <= '0;
    end else if (en) begin
      v3     <= v2;
      dout_q <= dout_c;
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_data  = dout_q;

`ifdef COLOR_CONVERT_SAT_FLAG_EN
  logic sat_q, sticky_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (en) begin
        sat_q <= sat_c;
      end
      if (v3 && bus.out_ready && sat_q) begin
        sticky_q <= 1'b1;
      end
    end
  end

  assign bus.out_sat    = sat_q;
  assign bus.sat_sticky = sticky_q;
`endif

endmodule
